// File: rtl/au_writeback_stage_if.sv
// Bundles the issue-side and writeback-side handshakes of au_writeback_stage.
// master: arithmetic unit and register file side; slave: the writeback stage.
interface au_writeback_stage_if #(
  parameter int unsigned WORD_SIZE   = 19,
  parameter int unsigned OPCODE_SIZE = 3,
  parameter int unsigned REG_ADDR_W  = 3
);
  logic                   in_valid;
  logic                   in_ready;
  logic [OPCODE_SIZE-1:0] in_opcode;
  logic [WORD_SIZE-1:0]   in_op1;
  logic [WORD_SIZE-1:0]   in_op2;
  logic [WORD_SIZE-1:0]   in_result;
  logic [REG_ADDR_W-1:0]  in_rd;

  logic                   wb_valid;
  logic                   wb_ready;
  logic [REG_ADDR_W-1:0]  wb_rd;
  logic [WORD_SIZE-1:0]   wb_data;
  logic [3:0]             wb_flags;

  modport master (
    output in_valid, in_opcode, in_op1, in_op2, in_result, in_rd, wb_ready,
    input  in_ready, wb_valid, wb_rd, wb_data, wb_flags
  );

  modport slave (
    input  in_valid, in_opcode, in_op1, in_op2, in_result, in_rd, wb_ready,
    output in_ready, wb_valid, wb_rd, wb_data, wb_flags
  );
endinterface

// File: rtl/au_writeback_stage.sv
// Writeback stage after the combinational arithmetic unit.
// Computes {DZ,C,N,Z} at capture, queues entries in a DEPTH-entry FIFO, drives
// register-file writeback from the head and keeps the architectural flags of
// the last retired entry.
// Optional: define AU_WB_STATS_EN to add retired_cnt / dz_cnt saturating counters.
// Opcode encoding: ADD=0 SUB=1 MUL=2 DIV=3 INC=4 DEC=5 (OPCODE_SIZE=3).
module au_writeback_stage #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  au_writeback_stage_if.slave  bus,
  output logic [3:0]           flags_q
`ifdef AU_WB_STATS_EN
  ,
  output logic [31:0]          retired_cnt,
  output logic [15:0]          dz_cnt
`endif
);

  localparam int unsigned WORD_SIZE   = 19;
  localparam int unsigned OPCODE_SIZE = 3;

  localparam logic [OPCODE_SIZE-1:0] ADD = 3'd0;
  localparam logic [OPCODE_SIZE-1:0] SUB = 3'd1;
  localparam logic [OPCODE_SIZE-1:0] MUL = 3'd2;
  localparam logic [OPCODE_SIZE-1:0] DIV = 3'd3;
  localparam logic [OPCODE_SIZE-1:0] INC = 3'd4;
  localparam logic [OPCODE_SIZE-1:0] DEC = 3'd5;

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WORD_SIZE-1:0]  data_mem  [DEPTH];
  logic [REG_ADDR_W-1:0] rd_mem    [DEPTH];
  logic [3:0]            flags_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic full, empty, push, pop;

  logic [WORD_SIZE-1:0]   push_data;
  logic [3:0]             push_flags;
  logic                   carry, dz;
  logic [2*WORD_SIZE-1:0] product;
  logic [WORD_SIZE:0]     sum;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

  // No bypass: a full queue refuses input even when popping this cycle.
  assign push = bus.in_valid && !full;
  assign pop  = !empty && bus.wb_ready;

  assign bus.in_ready = !full;
  assign bus.wb_valid = !empty;

  // Head entry presented for writeback, zeroed while the queue is empty.
  always_comb begin
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.wb_flags = '0;
    if (!empty) begin
      bus.wb_rd    = rd_mem[rd_ptr_q];
      bus.wb_data  = data_mem[rd_ptr_q];
      bus.wb_flags = flags_mem[rd_ptr_q];
    end
  end

  // Stored data and status flags for the incoming entry.
  always_comb begin
    push_data = bus.in_result;
    carry     = 1'b0;
    dz        = 1'b0;
    sum       = {1'b0, bus.in_op1} + {1'b0, bus.in_op2};
    product   = {{WORD_SIZE{1'b0}}, bus.in_op1} * {{WORD_SIZE{1'b0}}, bus.in_op2};
    case (bus.in_opcode)
      ADD: carry = sum[WORD_SIZE];
      SUB: carry = (bus.in_op1 < bus.in_op2);
      MUL: carry = ((product >> WORD_SIZE) != '0);
      DIV: begin
        if (bus.in_op2 == '0) begin
          dz        = 1'b1;
          push_data = '1;
        end
      end
      INC: carry = (bus.in_op1 == '1);
      DEC: carry = (bus.in_op1 == '0);
      default: carry = 1'b0;
    endcase
    push_flags = {dz, carry, push_data[WORD_SIZE-1], (push_data == '0)};
  end

  // Unused sum bits are the plain sum; only the carry-out matters.
  logic unused_sum;
  assign unused_sum = ^sum[WORD_SIZE-1:0];

  // Queue storage; contents need no reset because outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q]  <= push_data;
      rd_mem[wr_ptr_q]    <= bus.in_rd;
      flags_mem[wr_ptr_q] <= push_flags;
    end
  end

  // Pointers, occupancy and architectural flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      flags_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        flags_q  <= flags_mem[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef AU_WB_STATS_EN
  // Saturating retirement and divide-by-zero counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt <= '0;
      dz_cnt      <= '0;
    end else begin
      if (pop && (retired_cnt != '1))       retired_cnt <= retired_cnt + 1'b1;
      if (push && dz && (dz_cnt != '1))     dz_cnt      <= dz_cnt + 1'b1;
    end
  end
`endif

endmodule
